// File: rtl/conv_pkg.sv
// Shared definitions for the frame scheduler: FSM state encoding and output-grid size helpers.
package conv_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ISSUE   = 3'd1,
        ST_WAIT    = 3'd2,
        ST_WRITE   = 3'd3,
        ST_ADVANCE = 3'd4,
        ST_FINISH  = 3'd5
    } state_e;

    // Number of window positions along one axis.
    function automatic int unsigned out_dim(input int unsigned img, input int unsigned k,
                                            input int unsigned s);
        return (img - k) / s + 32'd1;
    endfunction

    function automatic int unsigned num_out(input int unsigned w, input int unsigned h,
                                            input int unsigned k, input int unsigned s);
        return out_dim(w, k, s) * out_dim(h, k, s);
    endfunction

endpackage

// File: rtl/conv_frame_scheduler_if.sv
// Engine handshake and output-SRAM write port of the frame scheduler.
interface conv_frame_scheduler_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
);
    logic                  o_eng_start;
    logic [ADDR_WIDTH-1:0] o_eng_base;
    logic                  i_eng_done;
    logic [DATA_WIDTH-1:0] i_eng_result;
    logic                  o_out_we;
    logic [ADDR_WIDTH-1:0] o_out_addr;
    logic [DATA_WIDTH-1:0] o_out_data;

    modport master (
        output o_eng_start, o_eng_base, o_out_we, o_out_addr, o_out_data,
        input  i_eng_done, i_eng_result
    );

    modport slave (
        input  o_eng_start, o_eng_base, o_out_we, o_out_addr, o_out_data,
        output i_eng_done, i_eng_result
    );
endinterface

// File: rtl/conv_pos_counter.sv
// Window position tracker: row/col advance by STRIDE with column wrap, plus raster output index.
module conv_pos_counter
    import conv_pkg::*;
#(
    parameter int IMG_W       = 8,
    parameter int IMG_H       = 8,
    parameter int KERNEL_SIZE = 3,
    parameter int STRIDE      = 1,
    parameter int ADDR_WIDTH  = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_clear,
    input  logic                  i_step,
    output logic [ADDR_WIDTH-1:0] o_row,
    output logic [ADDR_WIDTH-1:0] o_col,
    output logic [ADDR_WIDTH-1:0] o_idx,
    output logic                  o_last
);
    localparam int unsigned OUT_W = out_dim(IMG_W, KERNEL_SIZE, STRIDE);
    localparam int unsigned NUM_OUT = num_out(IMG_W, IMG_H, KERNEL_SIZE, STRIDE);
    localparam logic [ADDR_WIDTH-1:0] LAST_COL = ADDR_WIDTH'((OUT_W - 1) * STRIDE);
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(NUM_OUT - 1);
    localparam logic [ADDR_WIDTH-1:0] STEP     = ADDR_WIDTH'(STRIDE);
    localparam logic [ADDR_WIDTH-1:0] ONE      = ADDR_WIDTH'(1);

    logic [ADDR_WIDTH-1:0] row_q, row_d, col_q, col_d, idx_q, idx_d;
    logic                  col_wrap_s;

    // Next position: clear to origin, or step one window in raster order.
    always_comb begin
        row_d      = row_q;
        col_d      = col_q;
        idx_d      = idx_q;
        col_wrap_s = (col_q == LAST_COL);
        if (i_clear) begin
            row_d = '0;
            col_d = '0;
            idx_d = '0;
        end else if (i_step) begin
            if (col_wrap_s) begin
                col_d = '0;
                row_d = row_q + STEP;
            end else begin
                col_d = col_q + STEP;
                row_d = row_q;
            end
            idx_d = idx_q + ONE;
        end else begin
            idx_d = idx_q;
        end
    end

    // Position registers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            row_q <= '0;
            col_q <= '0;
            idx_q <= '0;
        end else begin
            row_q <= row_d;
            col_q <= col_d;
            idx_q <= idx_d;
        end
    end

    assign o_row  = row_q;
    assign o_col  = col_q;
    assign o_idx  = idx_q;
    assign o_last = (idx_q == LAST_IDX);
endmodule

// File: rtl/conv_frame_scheduler.sv
// Frame sequencer: issues every convolution window to the engine and writes results in raster order.
module conv_frame_scheduler
    import conv_pkg::*;
#(
    parameter int IMG_W       = 8,
    parameter int IMG_H       = 8,
    parameter int KERNEL_SIZE = 3,
    parameter int STRIDE      = 1,
    parameter int DATA_WIDTH  = 8,
    parameter int ADDR_WIDTH  = 8,
    parameter int TIMEOUT     = 255
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_start,
    input  logic                   i_abort,
    conv_frame_scheduler_if.master bus,
    output logic                   o_busy,
    output logic                   o_done,
    output logic                   o_error
);
    localparam int WAIT_W = $clog2(TIMEOUT + 1);
    localparam logic [WAIT_W-1:0]     WAIT_MAX = WAIT_W'(TIMEOUT);
    localparam logic [WAIT_W-1:0]     WAIT_ONE = WAIT_W'(1);
    localparam logic [ADDR_WIDTH-1:0] IMG_W_C  = ADDR_WIDTH'(IMG_W);

    state_e                state_q, state_d;
    logic [WAIT_W-1:0]     wait_q, wait_d;
    logic [DATA_WIDTH-1:0] result_q, result_d;
    logic                  error_q, error_d;
    logic                  clear_s, step_s, last_s;
    logic [ADDR_WIDTH-1:0] row_s, col_s, idx_s;
    logic                  eng_start_q, out_we_q, busy_q, done_q;
    logic [ADDR_WIDTH-1:0] out_addr_q;
    logic [DATA_WIDTH-1:0] out_data_q;

    conv_pos_counter #(
        .IMG_W(IMG_W), .IMG_H(IMG_H), .KERNEL_SIZE(KERNEL_SIZE),
        .STRIDE(STRIDE), .ADDR_WIDTH(ADDR_WIDTH)
    ) u_pos (
        .i_clk(i_clk), .i_rst(i_rst), .i_clear(clear_s), .i_step(step_s),
        .o_row(row_s), .o_col(col_s), .o_idx(idx_s), .o_last(last_s)
    );

    // Next-state logic; abort overrides everything, including a same-cycle engine done.
    always_comb begin
        state_d  = state_q;
        wait_d   = wait_q;
        result_d = result_q;
        error_d  = error_q;
        clear_s  = 1'b0;
        step_s   = 1'b0;
        if (i_abort && (state_q != ST_IDLE)) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (i_start) begin
                        clear_s = 1'b1;
                        error_d = 1'b0;
                        state_d = ST_ISSUE;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_ISSUE: begin
                    wait_d  = WAIT_ONE;
                    state_d = ST_WAIT;
                end
                ST_WAIT: begin
                    if (bus.i_eng_done) begin
                        result_d = bus.i_eng_result;
                        state_d  = ST_WRITE;
                    end else if (wait_q == WAIT_MAX) begin
                        error_d = 1'b1;
                        state_d = ST_FINISH;
                    end else begin
                        wait_d = wait_q + WAIT_ONE;
                    end
                end
                ST_WRITE:   state_d = ST_ADVANCE;
                ST_ADVANCE: begin
                    if (last_s) begin
                        state_d = ST_FINISH;
                    end else begin
                        step_s  = 1'b1;
                        state_d = ST_ISSUE;
                    end
                end
                ST_FINISH:  state_d = ST_IDLE;
                default:    state_d = ST_IDLE;
            endcase
        end
    end

    // State and output registers; outputs are decoded from the next state so they align with it.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= ST_IDLE;
            wait_q      <= '0;
            result_q    <= '0;
            error_q     <= 1'b0;
            eng_start_q <= 1'b0;
            out_we_q    <= 1'b0;
            out_addr_q  <= '0;
            out_data_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_q      <= wait_d;
            result_q    <= result_d;
            error_q     <= error_d;
            eng_start_q <= (state_d == ST_ISSUE);
            out_we_q    <= (state_d == ST_WRITE);
            out_addr_q  <= (state_d == ST_WRITE) ? idx_s : '0;
            out_data_q  <= (state_d == ST_WRITE) ? result_d : '0;
            busy_q      <= (state_d != ST_IDLE);
            done_q      <= (state_d == ST_FINISH);
        end
    end

    // Row/col only move in ADVANCE, so the base stays stable from ISSUE through WRITE.
    assign bus.o_eng_base  = row_s * IMG_W_C + col_s;
    assign bus.o_eng_start = eng_start_q;
    assign bus.o_out_we    = out_we_q;
    assign bus.o_out_addr  = out_addr_q;
    assign bus.o_out_data  = out_data_q;
    assign o_busy          = busy_q;
    assign o_done          = done_q;
    assign o_error         = error_q;
endmodule
